// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the write port of a single synchronous FIFO between N_REQ producers.
// Ownership is granted round-robin and is burst-based. The owner keeps the
// port for up to MAX_BURST beats, or until it drops its request. The block
// sits directly in front of the FIFO write side. The read side is untouched.
//
// Optional feature (compile-time macro FIFO_ARB_PRIO_EN):
//   When defined, requester 0 is high priority. In IDLE, req[0] wins
//   regardless of the round-robin pointer, and the pointer is left unchanged
//   when a requester-0 burst ends. A burst in progress is never pre-empted.
//   When undefined, arbitration is pure round-robin and all requesters are equal.
//
// Parameters:
//   N_REQ      number of requesters (>= 2)
//   DATA_W     data width, equal to the FIFO width
//   MAX_BURST  maximum beats per grant (>= 1)
//
// Ports:
//   clk          clock; all state changes on posedge
//   rst          asynchronous reset, active-high
//   req          req[i]=1: requester i presents a beat on wdata slice i
//   wdata        packed data, slice i = wdata[i*DATA_W +: DATA_W]
//   ack          one-hot; ack[i]=1: slice i is written this cycle
//   fifo_full    FIFO full flag
//   fifo_wr_en   FIFO write enable
//   fifo_wdata   FIFO write data
//   grant_valid  1 while a burst is owned
//   grant_id     index of the current (or most recent) owner
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W    = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr_en,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic                      grant_valid,
  output logic [ID_W-1:0]           grant_id
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  logic [0:0]       state,    state_nxt;
  logic [ID_W-1:0]  owner,    owner_nxt;
  logic [ID_W-1:0]  ptr,      ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin search: first requester at or after ptr, wrapping at N_REQ.
  // ---------------------------------------------------------------------------
  logic            rr_found;
  logic [ID_W-1:0] rr_pick;

  // NOTE: every signal written in an always_comb block gets a default value
  // first, so no path through the block leaves it unassigned (no latch).
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!rr_found && req[(int'(ptr) + i) % N_REQ]) begin
        rr_found = 1'b1;
        rr_pick  = ID_W'((int'(ptr) + i) % N_REQ);
      end
    end
  end

  // Winner of the IDLE arbitration.
  logic [ID_W-1:0] win_id;

`ifdef FIFO_ARB_PRIO_EN
  // Requester 0 overrides the round-robin order whenever it is requesting.
  assign win_id = req[0] ? '0 : rr_pick;
`else
  assign win_id = rr_pick;
`endif

  // ---------------------------------------------------------------------------
  // Write qualification and datapath
  // ---------------------------------------------------------------------------
  logic in_burst;
  logic owner_req;
  logic wr_ok;
  logic last_beat;
  logic burst_end;

  assign in_burst  = (state == ST_BURST);
  assign owner_req = req[owner];
  // A beat is written only when the owner is requesting and the FIFO has room.
  // Holding off on full is what keeps fifo_wr_en low while fifo_full is set.
  assign wr_ok     = in_burst & owner_req & ~fifo_full;
  assign last_beat = (beat_cnt == LAST_BEAT);
  // Either the owner gave up (no write this cycle) or the final beat goes out.
  assign burst_end = in_burst & (~owner_req | (wr_ok & last_beat));

  assign fifo_wr_en  = wr_ok;
  assign ack         = wr_ok ? (N_REQ'(1) << owner) : '0;
  assign fifo_wdata  = in_burst ? wdata[int'(owner)*DATA_W +: DATA_W] : '0;
  assign grant_valid = in_burst;
  assign grant_id    = owner;

  // Pointer value used on burst exit: one past the owner, wrapping to 0.
  logic [ID_W-1:0] owner_inc;
  assign owner_inc = (owner == LAST_ID) ? '0 : owner + ID_W'(1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    ptr_nxt      = ptr;
    beat_cnt_nxt = beat_cnt;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt    = ST_BURST;
          owner_nxt    = win_id;
          beat_cnt_nxt = '0;
        end
      end

      ST_BURST: begin
        if (burst_end) begin
          state_nxt    = ST_IDLE;
          beat_cnt_nxt = '0;
`ifdef FIFO_ARB_PRIO_EN
          // A requester-0 burst does not advance the rotation of the others.
          if (owner != '0) begin
            ptr_nxt = owner_inc;
          end
`else
          ptr_nxt = owner_inc;
`endif
        end else if (wr_ok) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
        // Owner requesting while the FIFO is full: everything holds.
      end

      default: begin
        state_nxt    = ST_IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= '0;
      ptr      <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  a_no_write_when_full : assert property (
    @(posedge clk) disable iff (rst) fifo_full |-> !fifo_wr_en);

  a_ack_onehot : assert property (
    @(posedge clk) disable iff (rst) $onehot0(ack));

  a_ack_matches_wr_en : assert property (
    @(posedge clk) disable iff (rst) (|ack) == fifo_wr_en);

  a_beat_cnt_range : assert property (
    @(posedge clk) disable iff (rst) beat_cnt <= LAST_BEAT);

endmodule
